// File: rtl/maxpool2x2_stream_if.sv
// Stream bundle for maxpool2x2_stream: activation input and pooled output handshakes.
// Defining MAXPOOL_TLAST_EN adds the out_last frame marker.
interface maxpool2x2_stream_if #(
    parameter int BIT_REP = 8
);
    logic signed [BIT_REP-1:0] in_data;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [BIT_REP-1:0] out_data;
    logic                      out_valid;
    logic                      out_ready;
`ifdef MAXPOOL_TLAST_EN
    logic                      out_last;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );
`else
    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );
    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );
`endif
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 signed max pooling over raster-order frames, one output register stage.
// Optional frame marker out_last is built when MAXPOOL_TLAST_EN is defined.
module maxpool2x2_stream #(
    parameter int BIT_REP   = 8,
    parameter int IN_WIDTH  = 8,
    parameter int IN_LENGTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    maxpool2x2_stream_if.slave strm
);
    localparam int HALF_W = IN_WIDTH / 2;
    localparam int COL_W  = $clog2(IN_WIDTH);
    localparam int ROW_W  = $clog2(IN_LENGTH);
    localparam int LB_W   = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IN_LENGTH - 1);

    function automatic logic signed [BIT_REP-1:0] smax(
        input logic signed [BIT_REP-1:0] a,
        input logic signed [BIT_REP-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    logic [COL_W-1:0]          col_q, col_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic signed [BIT_REP-1:0] hold_q, hold_d;
    logic signed [BIT_REP-1:0] out_data_q, out_data_d;
    logic                      out_valid_q, out_valid_d;
    logic signed [BIT_REP-1:0] lb_q [HALF_W];
    logic [LB_W-1:0]           lb_idx;
    logic                      lb_we;
    logic signed [BIT_REP-1:0] pair_max;
    logic signed [BIT_REP-1:0] pool_max;
    logic                      in_xfer;
    logic                      out_xfer;

    assign strm.in_ready = !out_valid_q || strm.out_ready;
    assign in_xfer       = strm.in_valid && strm.in_ready;
    assign out_xfer      = out_valid_q && strm.out_ready;
    assign lb_idx        = LB_W'(col_q >> 1);

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        hold_d      = hold_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        lb_we       = 1'b0;
        pair_max    = smax(hold_q, strm.in_data);
        pool_max    = smax(lb_q[lb_idx], pair_max);

        if (out_xfer) begin
            out_valid_d = 1'b0;
        end

        if (in_xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            // Even column opens a pair; odd column closes it into the line buffer or the output.
            if (!col_q[0]) begin
                hold_d = strm.in_data;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                out_data_d  = pool_max;
                out_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hold_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hold_q      <= hold_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Line buffer is always written in the even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_idx] <= pair_max;
        end
    end

    assign strm.out_data  = out_data_q;
    assign strm.out_valid = out_valid_q;

`ifdef MAXPOOL_TLAST_EN
    logic out_last_q, out_last_d;

    always_comb begin
        out_last_d = out_last_q;
        if (out_xfer) begin
            out_last_d = 1'b0;
        end
        if (in_xfer && col_q[0] && row_q[0]) begin
            out_last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_last_q <= 1'b0;
        end else begin
            out_last_q <= out_last_d;
        end
    end

    assign strm.out_last = out_last_q;
`endif
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Self-checking bench for maxpool2x2_stream (4x4 frames, 8-bit): directed frames plus randomized
// gaps/backpressure against a frame-array reference model.
module tb_maxpool2x2_stream;
    localparam int W = 4;
    localparam int L = 4;

    typedef struct {
        int data;
        bit last;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    maxpool2x2_stream_if #(.BIT_REP(8)) bus ();

    maxpool2x2_stream #(
        .BIT_REP  (8),
        .IN_WIDTH (W),
        .IN_LENGTH(L)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .strm (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: accepted pixels fill a 2D frame; each completed 2x2 block yields its max.
    int   frame_m [L][W];
    int   pix_cnt;
    exp_t exp_q [$];
    int   got_q [$];
    int   got_last_q [$];
    bit   exp_valid_next;
    bit   prev_stall;
    int   prev_data;

    always @(negedge clk) begin
        int   r, c, m;
        exp_t e;
        if (!rst_n) begin
            check_eq("rst_out_valid", int'(bus.out_valid), 0);
            check_eq("rst_out_data", int'(bus.out_data), 0);
`ifdef MAXPOOL_TLAST_EN
            check_eq("rst_out_last", int'(bus.out_last), 0);
`endif
            pix_cnt        = 0;
            exp_q.delete();
            exp_valid_next = 1'b0;
            prev_stall     = 1'b0;
        end else begin
            check_eq("in_ready_rule", int'(bus.in_ready), int'(!bus.out_valid || bus.out_ready));
            if (exp_valid_next) check_eq("latency_valid", int'(bus.out_valid), 1);
            exp_valid_next = 1'b0;
            if (prev_stall) begin
                check_eq("stall_hold_valid", int'(bus.out_valid), 1);
                check_eq("stall_hold_data", int'(bus.out_data), prev_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = int'(bus.out_data);

            if (bus.out_valid && bus.out_ready) begin
                check_eq("output_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq("out_data", int'(bus.out_data), e.data);
`ifdef MAXPOOL_TLAST_EN
                    check_eq("out_last", int'(bus.out_last), int'(e.last));
                    got_last_q.push_back(int'(bus.out_last));
`endif
                end
                got_q.push_back(int'(bus.out_data));
            end

            if (bus.in_valid && bus.in_ready) begin
                r = pix_cnt / W;
                c = pix_cnt % W;
                frame_m[r][c] = int'(bus.in_data);
                if ((r % 2 == 1) && (c % 2 == 1)) begin
                    m = frame_m[r-1][c-1];
                    if (frame_m[r-1][c] > m) m = frame_m[r-1][c];
                    if (frame_m[r][c-1] > m) m = frame_m[r][c-1];
                    if (frame_m[r][c] > m)   m = frame_m[r][c];
                    e.data = m;
                    e.last = (r == L - 1) && (c == W - 1);
                    exp_q.push_back(e);
                    exp_valid_next = 1'b1;
                end
                pix_cnt = (pix_cnt + 1) % (W * L);
            end
        end
    end

    // Consumer: 0 = always ready, 1 = random, 2 = three-cycle stall on the first output.
    int sink_mode  = 0;
    int stall_left = 0;
    bit stall_done = 1'b0;

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (sink_mode)
                1: bus.out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (stall_left > 0) begin
                        bus.out_ready = 1'b0;
                        stall_left--;
                    end else if (!stall_done && bus.out_valid) begin
                        bus.out_ready = 1'b0;
                        stall_left    = 2;
                        stall_done    = 1'b1;
                    end else begin
                        bus.out_ready = 1'b1;
                    end
                end
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    task automatic send_pixels(input int px[$], input int gap_pct, output int cycles);
        int i = 0;
        bit acc;
        cycles = 0;
        while (i < px.size()) begin
            bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
            bus.in_data  = 8'(px[i]);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (acc) i++;
            if (cycles > 4000) begin
                $display("FAIL send_timeout: got %0d pixels accepted expected %0d", i, px.size());
                $fatal(1, "input side stuck");
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_done", int'(n < 500), 1);
    endtask

    task automatic check_seq(input string tag, input int exp_s[$]);
        check_eq({tag, "_count"}, got_q.size(), exp_s.size());
        for (int k = 0; k < exp_s.size() && k < got_q.size(); k++) begin
            check_eq(tag, got_q[k], exp_s[k]);
        end
    endtask

    initial begin
        int px[$];
        int seq_up[$];
        int seq_dn[$];
        int exp_s[$];
        int cyc;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        rst_n        = 1'b0;
        for (int k = 0; k < 16; k++) begin
            seq_up.push_back(k);
            seq_dn.push_back(15 - k);
        end
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain frame, always ready: in_ready stays 1, one-cycle latency checked by the monitor.
        got_q.delete();
        got_last_q.delete();
        send_pixels(seq_up, 0, cyc);
        drain();
        exp_s = '{5, 7, 13, 15};
        check_seq("frame_up", exp_s);
`ifdef MAXPOOL_TLAST_EN
        exp_s = '{0, 0, 0, 1};
        check_eq("last_count", got_last_q.size(), 4);
        for (int k = 0; k < 4 && k < got_last_q.size(); k++) check_eq("last_flag", got_last_q[k], exp_s[k]);
`endif

        // Backpressure on the first output.
        got_q.delete();
        stall_done = 1'b0;
        stall_left = 0;
        sink_mode  = 2;
        send_pixels(seq_up, 0, cyc);
        drain();
        sink_mode = 0;
        check_eq("stall_happened", int'(stall_done), 1);
        exp_s = '{5, 7, 13, 15};
        check_seq("frame_stall", exp_s);

        // Negative values and a full -128 block.
        got_q.delete();
        px = '{-8, -3, -128, -128, -128, -4, -128, -128};
        for (int k = 0; k < 8; k++) px.push_back(-int'($urandom_range(1, 128)));
        send_pixels(px, 0, cyc);
        drain();
        check_eq("neg_count", got_q.size(), 4);
        if (got_q.size() >= 2) begin
            check_eq("neg_block0", got_q[0], -3);
            check_eq("neg_block1", got_q[1], -128);
        end

        // Back-to-back frames with no idle cycle between them.
        got_q.delete();
        px = seq_up;
        foreach (seq_dn[k]) px.push_back(seq_dn[k]);
        send_pixels(px, 0, cyc);
        check_eq("b2b_cycles", cyc, 32);
        drain();
        exp_s = '{5, 7, 13, 15, 15, 13, 7, 5};
        check_seq("frame_b2b", exp_s);

        // Reset after six pixels; the aborted block must never reach the output.
        px = '{100, 101, 102, 103, 104, 105};
        send_pixels(px, 0, cyc);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        got_q.delete();
        send_pixels(seq_up, 0, cyc);
        drain();
        exp_s = '{5, 7, 13, 15};
        check_seq("frame_after_rst", exp_s);

        // Randomized data, input gaps and consumer stalls over several frames.
        got_q.delete();
        px.delete();
        for (int k = 0; k < 3 * 16; k++) px.push_back(int'($urandom_range(0, 255)) - 128);
        sink_mode = 1;
        send_pixels(px, 30, cyc);
        sink_mode = 0;
        drain();
        check_eq("rand_count", got_q.size(), 12);
        check_eq("model_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/maxpool2x2_stream.md
MAXPOOL2X2_STREAM -- requirements
Module: maxpool2x2_stream

Interface
REQ-001 Parameter BIT_REP, default 8: signed element width in bits.
REQ-002 Parameter IN_WIDTH, default 8: pixels per input row; even, >= 2.
REQ-003 Parameter IN_LENGTH, default 8: rows per input frame; even, >= 2.
REQ-004 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_data  input  BIT_REP  signed activation from the ReLU stage, raster order (row-major, column fastest).
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_ready  output  1  block can accept in_data this cycle.
REQ-010 out_data  output  BIT_REP  signed pooled value.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  consumer accepts out_data this cycle.
REQ-013 out_last  output  1  last pooled value of a frame (present only with MAXPOOL_TLAST_EN).

Function
REQ-014 The block SHALL compute 2x2 stride-2 max pooling, producing (IN_WIDTH/2)*(IN_LENGTH/2) outputs per frame in raster order.
REQ-015 Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-016 in_ready SHALL equal !out_valid || out_ready (combinational pass-through of out_ready permitted).
REQ-017 Column counter col (0..IN_WIDTH-1) and row counter row (0..IN_LENGTH-1) SHALL advance only on input transfer; col wraps to 0 and increments row; row wraps to 0 after the last pixel of a frame, so back-to-back frames need no idle cycle.
REQ-018 On an even-column transfer, in_data SHALL be captured in a hold register.
REQ-019 On an odd-column transfer in an even row, max(hold, in_data) SHALL be written to line-buffer entry col>>1 (IN_WIDTH/2 entries of BIT_REP bits).
REQ-020 On an odd-column transfer in an odd row, max(linebuf[col>>1], hold, in_data) SHALL be loaded into out_data and out_valid set on the next edge (latency 1 cycle from the completing input).
REQ-021 All comparisons SHALL be signed BIT_REP-bit; ties select either operand (value identical); no width growth.
REQ-022 out_data and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 out_valid SHALL clear after an output transfer unless a new result is loaded on the same edge, in which case out_valid stays 1 with the new data.
REQ-024 in_valid low or stall SHALL leave counters, hold and line buffer unchanged.

Reset
REQ-025 While rst_n is low: col=0, row=0, hold=0, out_data=0, out_valid=0, out_last=0; line buffer is not reset (always written before read).
REQ-026 Reset mid-frame SHALL discard the partial frame; the first transfer after release is pixel (0,0) of a new frame.

Configuration
REQ-027 Macro MAXPOOL_TLAST_EN defined: out_last port exists and SHALL be 1 with the output produced at row=IN_LENGTH-1, col=IN_WIDTH-1, otherwise 0, held with out_data.
REQ-028 Macro MAXPOOL_TLAST_EN undefined: out_last port and its logic SHALL be absent; all other behaviour identical.

Verification (IN_WIDTH=4, IN_LENGTH=4, BIT_REP=8)
REQ-029 Frame 0..15 raster, in_valid=1, out_ready=1 -> outputs 5,7,13,15, each 1 cycle after inputs 5,7,13,15 accepted; in_ready constantly 1.
REQ-030 Same frame, out_ready=0 for 3 cycles after first out_valid -> out_data=5 held, in_ready=0, no input lost; sequence still 5,7,13,15.
REQ-031 Signed frame with all values negative, block (0,0)={-8,-3,-128,-4} -> first output -3; block of all -128 -> -128.
REQ-032 Two frames back-to-back (0..15 then 15..0) -> 5,7,13,15 then 15,13,7,5 (for the reversed frame the maxima are the upper-left pixels of each block); no bubble between frames.
REQ-033 rst_n low after 6 inputs of frame, then new frame 0..15 -> out_valid 0 during reset; outputs exactly 5,7,13,15, nothing from the aborted frame.
REQ-034 MAXPOOL_TLAST_EN defined, frame 0..15 -> out_last=1 only with out_data=15.
